seq_code_lock: RTL and testbench

Sequential, parametrised keypad code lock that succeeds the team's combinational numeric lock.
- Accepts one digit per strobe and compares the entry on the fly against a parameter code.
- Counts failed attempts and enforces a timed alarm lockout after MAX_TRIES failures.
- Sits between the keypad scanner and the ignition/door enable logic; correct_signal gates the car enable, alarm drives the buzzer/alert path.

---
 rtl/lock_pkg.sv | 29 ++
 rtl/lockout_timer.sv | 35 +++
 rtl/seq_code_lock.sv | 127 ++++++++++++
 tb/tb_seq_code_lock.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad code lock family.
// Pure declarations: no latency, no flow control.
package lock_pkg;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_t;

    localparam int DEFAULT_RADIX = 10;
    localparam int MAX_CODE_W    = 256;
    localparam int MAX_DIGIT_W   = 32;

    // Field i of a packed code, first digit in the most-significant field.
    function automatic logic [MAX_DIGIT_W-1:0] digit_at(
        input logic [MAX_CODE_W-1:0] code,
        input int                    code_len,
        input int                    digit_w,
        input int                    i
    );
        logic [MAX_CODE_W-1:0] shifted;
        logic [MAX_CODE_W-1:0] mask;
        shifted = code >> ((code_len - 1 - i) * digit_w);
        mask    = (MAX_CODE_W'(1) << digit_w) - MAX_CODE_W'(1);
        return MAX_DIGIT_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// One-shot down-counter: active is high for exactly LOCKOUT_CYC cycles after load.
// Outputs registered, done flags the final active cycle; load restarts, no backpressure.
module lockout_timer #(
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic active,
    output logic done
);

    localparam int TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            timer  <= '0;
        end else if (load) begin
            active <= 1'b1;
            timer  <= TW'(LOCKOUT_CYC - 1);
        end else if (active) begin
            if (timer == '0) begin
                active <= 1'b0;
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end

    assign done = active && (timer == '0);

endmodule

// File: rtl/seq_code_lock.sv
// Sequential keypad lock: checks digits on the fly, counts failures, times an alarm lockout.
// Result 1 cycle after the final digit; keys during UNLOCKED/LOCKOUT are dropped, no backpressure.
module seq_code_lock
    import lock_pkg::*;
#(
    parameter int                          CODE_LEN    = 4,
    parameter int                          DIGIT_W     = 4,
    parameter int                          RADIX       = DEFAULT_RADIX,
    parameter logic [CODE_LEN*DIGIT_W-1:0] CODE        = 16'h1234,
    parameter int                          MAX_TRIES   = 3,
    parameter int                          LOCKOUT_CYC = 1000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_valid,
    input  logic [DIGIT_W-1:0]               key_digit,
    input  logic                             clear,
    input  logic                             relock,
    output logic                             correct_signal,
    output logic                             alarm,
    output logic                             wrong_pulse,
    output logic                             locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]    digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

    localparam int IW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);

    lock_state_t   state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          mismatch, mismatch_nxt;
    logic [FW-1:0] fail_cnt, fail_nxt;
    logic          wrong_nxt;
    logic          tmr_load, tmr_active, tmr_done;
    logic [DIGIT_W-1:0] exp_digit;
    logic          digit_ok;
    logic          mis_acc;

    lockout_timer #(
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .active (tmr_active),
        .done   (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ENTRY;
            idx            <= '0;
            mismatch       <= 1'b0;
            fail_cnt       <= '0;
            wrong_pulse    <= 1'b0;
            correct_signal <= 1'b0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            mismatch       <= mismatch_nxt;
            fail_cnt       <= fail_nxt;
            wrong_pulse    <= wrong_nxt;
            correct_signal <= (state_nxt == UNLOCKED);
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        mismatch_nxt = mismatch;
        fail_nxt     = fail_cnt;
        wrong_nxt    = 1'b0;
        tmr_load     = 1'b0;
        exp_digit    = DIGIT_W'(digit_at(MAX_CODE_W'(CODE), CODE_LEN, DIGIT_W, int'(idx)));
        digit_ok     = int'(key_digit) < RADIX;
        mis_acc      = mismatch | (key_digit != exp_digit);

        case (state)
            ENTRY: begin
                // clear has priority and swallows any key presented with it
                if (clear) begin
                    idx_nxt      = '0;
                    mismatch_nxt = 1'b0;
                end else if (key_valid && digit_ok) begin
                    if (idx == IW'(CODE_LEN - 1)) begin
                        idx_nxt      = '0;
                        mismatch_nxt = 1'b0;
                        if (!mis_acc) begin
                            state_nxt = UNLOCKED;
                            fail_nxt  = '0;
                        end else if (int'(fail_cnt) + 1 < MAX_TRIES) begin
                            fail_nxt  = fail_cnt + 1'b1;
                            wrong_nxt = 1'b1;
                        end else begin
                            state_nxt = LOCKOUT;
                            fail_nxt  = FW'(MAX_TRIES);
                            wrong_nxt = 1'b1;
                            tmr_load  = 1'b1;
                        end
                    end else begin
                        idx_nxt      = idx + 1'b1;
                        mismatch_nxt = mis_acc;
                    end
                end
            end
            UNLOCKED: begin
                if (relock) begin
                    state_nxt = ENTRY;
                end
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    state_nxt = ENTRY;
                    fail_nxt  = '0;
                end
            end
            default: state_nxt = ENTRY;
        endcase
    end

    assign alarm       = tmr_active;
    assign locked_out  = tmr_active;
    assign digit_count = idx;
    assign fail_count  = fail_cnt;

endmodule

// File: tb/tb_seq_code_lock.sv
// Bench for seq_code_lock: directed key sequences queue expected events, a monitor
// pops and compares on each wrong_pulse / correct_signal edge / alarm edge.
module tb_seq_code_lock;

    localparam int EV_WRONG  = 0;
    localparam int EV_UNLOCK = 1;
    localparam int EV_RELOCK = 2;
    localparam int EV_AON    = 3;
    localparam int EV_AOFF   = 4;

    typedef struct {
        int kind;
        int fc;
        int len;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst[2];
    logic       kv[2];
    logic [3:0] kd[2];
    logic       clr[2];
    logic       rl[2];
    logic       cs[2], al[2], wp[2], lo[2];
    logic [2:0] dc[2];
    logic [1:0] fc[2];

    ev_t  q0[$];
    ev_t  q1[$];
    int   checks = 0;
    int   fails  = 0;
    int   acnt[2];
    logic pcs[2], pal[2];

    always #5 clk = ~clk;

    seq_code_lock #(.CODE_LEN(4), .CODE(16'h1234)) dut0 (
        .clk(clk), .rst(rst[0]), .key_valid(kv[0]), .key_digit(kd[0]),
        .clear(clr[0]), .relock(rl[0]), .correct_signal(cs[0]), .alarm(al[0]),
        .wrong_pulse(wp[0]), .locked_out(lo[0]), .digit_count(dc[0]), .fail_count(fc[0])
    );

    seq_code_lock #(.CODE_LEN(6), .CODE(24'h908172)) dut1 (
        .clk(clk), .rst(rst[1]), .key_valid(kv[1]), .key_digit(kd[1]),
        .clear(clr[1]), .relock(rl[1]), .correct_signal(cs[1]), .alarm(al[1]),
        .wrong_pulse(wp[1]), .locked_out(lo[1]), .digit_count(dc[1]), .fail_count(fc[1])
    );

    task automatic expect_ev(input int d, input int kind, input int f, input int len);
        ev_t e;
        e.kind = kind;
        e.fc   = f;
        e.len  = len;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic see_ev(input int d, input int kind, input int len);
        ev_t e;
        checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            fails++;
            $display("FAIL ev_unexpected dut%0d: got kind=%0d fail_count=%0d, required no event",
                     d, kind, fc[d]);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (e.kind != kind || e.fc != int'(fc[d]) || dc[d] !== 3'd0 || lo[d] !== al[d]
                || (cs[d] && al[d]) || (e.len >= 0 && e.len != len)) begin
                fails++;
                $display("FAIL ev_dut%0d: got kind=%0d fail_count=%0d digit_count=%0d len=%0d alarm=%0b locked_out=%0b correct=%0b, required kind=%0d fail_count=%0d digit_count=0 len=%0d locked_out=alarm",
                         d, kind, fc[d], dc[d], len, al[d], lo[d], cs[d], e.kind, e.fc, e.len);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wp[d] === 1'b1) see_ev(d, EV_WRONG, 0);
            if (cs[d] === 1'b1 && pcs[d] === 1'b0) see_ev(d, EV_UNLOCK, 0);
            if (cs[d] === 1'b0 && pcs[d] === 1'b1) see_ev(d, EV_RELOCK, 0);
            if (al[d] === 1'b1 && pal[d] === 1'b0) begin
                acnt[d] = 1;
                see_ev(d, EV_AON, 0);
            end else if (al[d] === 1'b1) begin
                acnt[d]++;
            end
            if (al[d] === 1'b0 && pal[d] === 1'b1) see_ev(d, EV_AOFF, acnt[d]);
            pcs[d] = cs[d];
            pal[d] = al[d];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic key(input int d, input int v);
        kv[d] = 1'b1;
        kd[d] = 4'(v);
        tick();
        kv[d] = 1'b0;
        tick();
    endtask

    task automatic enter(input int d, input int n, input logic [23:0] code);
        logic [23:0] v;
        for (int i = 0; i < n; i++) begin
            v = (code >> ((n - 1 - i) * 4)) & 24'hF;
            key(d, int'(v));
        end
    endtask

    task automatic do_relock(input int d);
        rl[d] = 1'b1;
        tick();
        rl[d] = 1'b0;
        tick();
    endtask

    task automatic wait_alarm(input int d, input logic lvl, input int bound);
        int n;
        n = 0;
        while (al[d] !== lvl && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (al[d] !== lvl) begin
            fails++;
            $display("FAIL wait_alarm dut%0d: got alarm=%0b after %0d cycles, required %0b", d, al[d], n, lvl);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; kv[d] = 1'b0; kd[d] = 4'd0; clr[d] = 1'b0; rl[d] = 1'b0;
            acnt[d] = 0;
        end
        repeat (3) tick();
        chk("rst_correct", int'(cs[0]), 0);
        chk("rst_alarm", int'(al[0]), 0);
        chk("rst_wrong", int'(wp[0]), 0);
        chk("rst_locked_out", int'(lo[0]), 0);
        chk("rst_digit_count", int'(dc[0]), 0);
        chk("rst_fail_count", int'(fc[0]), 0);
        chk("rst1_fail_count", int'(fc[1]), 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();

        // basic unlock
        enter(0, 3, 24'h123);
        chk("partial_digit_count", int'(dc[0]), 3);
        expect_ev(0, EV_UNLOCK, 0, -1);
        key(0, 4);
        chk("unlock_alarm", int'(al[0]), 0);
        key(0, 1);
        chk("unlocked_ignores_keys", int'(dc[0]), 0);
        expect_ev(0, EV_RELOCK, 0, -1);
        do_relock(0);

        // one wrong entry, then correct
        expect_ev(0, EV_WRONG, 1, -1);
        enter(0, 4, 24'h1294);
        chk("after_wrong_correct", int'(cs[0]), 0);
        expect_ev(0, EV_UNLOCK, 0, -1);
        enter(0, 4, 24'h1234);
        expect_ev(0, EV_RELOCK, 0, -1);
        do_relock(0);

        // three wrong entries -> full lockout, ignored keys, timed release
        expect_ev(0, EV_WRONG, 1, -1);
        expect_ev(0, EV_WRONG, 2, -1);
        expect_ev(0, EV_WRONG, 3, -1);
        expect_ev(0, EV_AON, 3, -1);
        expect_ev(0, EV_AOFF, 0, 1000);
        for (int k = 0; k < 3; k++) enter(0, 4, 24'h5555);
        enter(0, 4, 24'h1234);
        chk("lockout_ignores_keys", int'(dc[0]), 0);
        chk("lockout_locked_out", int'(lo[0]), 1);
        chk("lockout_no_unlock", int'(cs[0]), 0);
        wait_alarm(0, 1'b0, 1100);
        chk("post_lockout_fail_count", int'(fc[0]), 0);
        expect_ev(0, EV_UNLOCK, 0, -1);
        enter(0, 4, 24'h1234);
        expect_ev(0, EV_RELOCK, 0, -1);
        do_relock(0);

        // clear with simultaneous key, then out-of-radix digit
        enter(0, 2, 24'h12);
        kv[0] = 1'b1; kd[0] = 4'd3; clr[0] = 1'b1;
        tick();
        kv[0] = 1'b0; clr[0] = 1'b0;
        tick();
        chk("clear_digit_count", int'(dc[0]), 0);
        key(0, 4'hA);
        chk("invalid_digit_ignored", int'(dc[0]), 0);
        expect_ev(0, EV_UNLOCK, 0, -1);
        enter(0, 4, 24'h1234);
        expect_ev(0, EV_RELOCK, 0, -1);
        do_relock(0);
        expect_ev(0, EV_WRONG, 1, -1);
        enter(0, 4, 24'h4321);
        chk("reversed_no_unlock", int'(cs[0]), 0);
        key(0, 1);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        tick();
        chk("clear_keeps_fail_count", int'(fc[0]), 1);
        chk("clear_alone_digit_count", int'(dc[0]), 0);

        // reset in the middle of a lockout
        expect_ev(0, EV_WRONG, 2, -1);
        expect_ev(0, EV_WRONG, 3, -1);
        expect_ev(0, EV_AON, 3, -1);
        expect_ev(0, EV_AOFF, 0, -1);
        enter(0, 4, 24'h5555);
        enter(0, 4, 24'h5555);
        wait_alarm(0, 1'b1, 10);
        repeat (498) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("rst_abort_alarm", int'(al[0]), 0);
        chk("rst_abort_fail_count", int'(fc[0]), 0);
        tick();
        expect_ev(0, EV_UNLOCK, 0, -1);
        enter(0, 4, 24'h1234);

        // six-digit instance
        expect_ev(1, EV_UNLOCK, 0, -1);
        enter(1, 6, 24'h908172);
        expect_ev(1, EV_RELOCK, 0, -1);
        do_relock(1);
        expect_ev(1, EV_WRONG, 1, -1);
        enter(1, 6, 24'h908173);
        expect_ev(1, EV_WRONG, 2, -1);
        enter(1, 6, 24'h900172);
        chk("len6_wrong_no_unlock", int'(cs[1]), 0);
        expect_ev(1, EV_UNLOCK, 0, -1);
        enter(1, 6, 24'h908172);

        repeat (5) tick();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
